eeprom_serial_ctrl: RTL and testbench



---
 rtl/eeprom_pkg.sv | 35 +++
 rtl/eeprom_spi_out.sv | 55 +++++
 rtl/eeprom_serial_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_eeprom_serial_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_pkg.sv
// rtl/eeprom_pkg.sv - shared constants, state type and size decode for the serial EEPROM emulator
package eeprom_pkg;

  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;

  localparam logic [1:0] SUB_EWDS = 2'b00;
  localparam logic [1:0] SUB_WRAL = 2'b01;
  localparam logic [1:0] SUB_ERAL = 2'b10;
  localparam logic [1:0] SUB_EWEN = 2'b11;

  localparam int CTRL_ERASE = 6;
  localparam int CTRL_WRITE = 5;
  localparam int CTRL_READ  = 4;
  localparam int CTRL_READY = 1;
  localparam int CTRL_RDONE = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_SPI_SHIFT,
    ST_DONE
  } state_t;

  function automatic logic [3:0] addr_width(input logic [1:0] size);
    case (size)
      2'd0:    return 4'd6;
      2'd1:    return 4'd8;
      default: return 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/eeprom_spi_out.sv
// rtl/eeprom_spi_out.sv - mode-0 SPI byte shifter running at half the system clock
module eeprom_spi_out #(
  parameter int BYTES_MAX = 4,
  localparam int PW = 8 * BYTES_MAX,
  localparam int CW = $clog2(BYTES_MAX + 1),
  localparam int BW = $clog2(PW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] count,
  input  logic [PW-1:0] payload,
  output logic          sel,
  output logic          sdo,
  output logic          sclk,
  output logic          done
);

  logic [PW-1:0] shift;
  logic [BW-1:0] bits_left;

  // High during the last rising phase: the frame closes on the next clock.
  assign done = sel & sclk & (bits_left == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= 1'b0;
      sdo       <= 1'b0;
      sclk      <= 1'b0;
      shift     <= '0;
      bits_left <= '0;
    end else if (load) begin
      sel       <= 1'b1;
      sclk      <= 1'b0;
      sdo       <= payload[PW-1];
      shift     <= payload << 1;
      bits_left <= BW'({count, 3'b000} - (CW + 3)'(1));
    end else if (sel) begin
      if (!sclk) begin
        sclk <= 1'b1;
      end else begin
        sclk <= 1'b0;
        if (bits_left == '0) begin
          sel <= 1'b0;
          sdo <= 1'b0;
        end else begin
          sdo       <= shift[PW-1];
          shift     <= shift << 1;
          bits_left <= bits_left - BW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/eeprom_serial_ctrl.sv
// rtl/eeprom_serial_ctrl.sv - 93Cx6-style serial EEPROM emulator with SPI mirroring of writes
module eeprom_serial_ctrl
  import eeprom_pkg::*;
#(
  parameter int SPI_BYTES_MAX = 4
) (
  input  logic        SClk,
  input  logic        nRst,
  input  logic        nWE,
  input  logic        nOE,
  input  logic [7:0]  WriteData,
  input  logic [1:0]  EEPROMSize,
  input  logic        SelSerialCtrl,
  input  logic        SelSerialComLo,
  input  logic        SelSerialComHi,
  input  logic        SelSerialDataLo,
  input  logic        SelSerialDataHi,
  output logic [7:0]  SerialCtrl,
  output logic [15:0] SerialCom,
  output logic [15:0] SerialData,
  output logic        SPISel,
  output logic        SPIDo,
  output logic        SPIClk
);

  localparam int PW = 8 * SPI_BYTES_MAX;
  localparam int CW = $clog2(SPI_BYTES_MAX + 1);

  state_t        state, state_next;
  logic          nwe_meta, nwe_sync, nwe_prev, commit;
  logic [15:0]   serial_com, serial_data;
  logic          wren, ready, rdone;
  logic [3:0]    n;
  logic [9:0]    addr_mask, addr;
  logic          start_bit;
  logic [1:0]    op, sub;
  logic          ctrl_start, is_read, is_ewen, is_ewds, is_fill, mirrored, four_byte, go;
  logic [9:0]    fill_addr, fill_last;
  logic [15:0]   fill_data;
  logic          spi_done, spi_fin;
  logic [CW-1:0] spi_count;
  logic [PW-1:0] spi_payload;
  logic          mem_we;
  logic [9:0]    mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem [0:1023];
  logic          unused_noe;

  assign unused_noe = nOE;
  assign commit     = nwe_sync & ~nwe_prev;
  assign ready      = (state == ST_IDLE);

  // Command fields move with the configured address width; bits above the start bit are don't-care.
  always_comb begin
    n         = addr_width(EEPROMSize);
    addr_mask = ~(10'h3FF << n);
    addr      = serial_com[9:0] & addr_mask;
    start_bit = serial_com[n + 4'd2];
    op        = {serial_com[n + 4'd1], serial_com[n]};
    sub       = {serial_com[n - 4'd1], serial_com[n - 4'd2]};
  end

  always_comb begin
    ctrl_start = commit & SelSerialCtrl & ready &
                 (WriteData[CTRL_ERASE] | WriteData[CTRL_WRITE] | WriteData[CTRL_READ]);
    is_read    = start_bit & (op == OP_READ);
    is_ewen    = start_bit & (op == OP_EXT) & (sub == SUB_EWEN);
    is_ewds    = start_bit & (op == OP_EXT) & (sub == SUB_EWDS);
    is_fill    = (op == OP_EXT) & ((sub == SUB_ERAL) | (sub == SUB_WRAL));
    mirrored   = start_bit & ((op == OP_WRITE) | (op == OP_ERASE) | is_fill);
    four_byte  = (op == OP_WRITE) | ((op == OP_EXT) & (sub == SUB_WRAL));
    go         = ctrl_start & mirrored & wren;
  end

  always_comb begin
    spi_count   = four_byte ? CW'(4) : CW'(2);
    spi_payload = '0;
    spi_payload[PW-1 -: 16] = serial_com;
    if (four_byte) spi_payload[PW-17 -: 16] = serial_data;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = fill_addr;
    mem_wdata = fill_data;
    if (state == ST_FILL) begin
      mem_we = 1'b1;
    end else if (go && op == OP_WRITE) begin
      mem_we    = 1'b1;
      mem_addr  = addr;
      mem_wdata = serial_data;
    end else if (go && op == OP_ERASE) begin
      mem_we    = 1'b1;
      mem_addr  = addr;
      mem_wdata = 16'hFFFF;
    end
  end

  always_ff @(posedge SClk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge SClk or negedge nRst) begin
    if (!nRst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Fill and shift run side by side; DONE holds until the SPI frame has also closed.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (go) state_next = is_fill ? ST_FILL : ST_SPI_SHIFT;
      ST_FILL:      if (fill_addr == fill_last) state_next = ST_DONE;
      ST_SPI_SHIFT: if (spi_done) state_next = ST_DONE;
      ST_DONE:      if (spi_fin) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge SClk or negedge nRst) begin
    if (!nRst) begin
      nwe_meta    <= 1'b1;
      nwe_sync    <= 1'b1;
      nwe_prev    <= 1'b1;
      serial_com  <= '0;
      serial_data <= '0;
      wren        <= 1'b0;
      rdone       <= 1'b0;
    end else begin
      nwe_meta <= nWE;
      nwe_sync <= nwe_meta;
      nwe_prev <= nwe_sync;
      if (commit && SelSerialComLo)  serial_com[7:0]   <= WriteData;
      if (commit && SelSerialComHi)  serial_com[15:8]  <= WriteData;
      if (commit && SelSerialDataLo) serial_data[7:0]  <= WriteData;
      if (commit && SelSerialDataHi) serial_data[15:8] <= WriteData;
      if (ctrl_start) begin
        rdone <= is_read;
        if (is_read) serial_data <= mem[addr];
        if (is_ewen) wren <= 1'b1;
        if (is_ewds) wren <= 1'b0;
      end
    end
  end

  always_ff @(posedge SClk or negedge nRst) begin
    if (!nRst) begin
      fill_addr <= '0;
      fill_last <= '0;
      fill_data <= '0;
      spi_fin   <= 1'b0;
    end else if (go) begin
      fill_addr <= '0;
      fill_last <= addr_mask;
      fill_data <= (sub == SUB_WRAL) ? serial_data : 16'hFFFF;
      spi_fin   <= 1'b0;
    end else begin
      if (state == ST_FILL) fill_addr <= fill_addr + 10'd1;
      if (spi_done) spi_fin <= 1'b1;
    end
  end

  eeprom_spi_out #(
    .BYTES_MAX(SPI_BYTES_MAX)
  ) u_spi (
    .clk    (SClk),
    .rst_n  (nRst),
    .load   (go),
    .count  (spi_count),
    .payload(spi_payload),
    .sel    (SPISel),
    .sdo    (SPIDo),
    .sclk   (SPIClk),
    .done   (spi_done)
  );

  assign SerialCtrl = {6'b0, ready, rdone};
  assign SerialCom  = serial_com;
  assign SerialData = serial_data;

endmodule

// File: tb/tb_eeprom_serial_ctrl.sv
// tb/tb_eeprom_serial_ctrl.sv - directed and randomized bench against a word-level EEPROM model
module tb_eeprom_serial_ctrl;

  logic        SClk = 1'b0;
  logic        nRst, nWE, nOE;
  logic [7:0]  WriteData;
  logic [1:0]  EEPROMSize;
  logic        SelSerialCtrl, SelSerialComLo, SelSerialComHi, SelSerialDataLo, SelSerialDataHi;
  logic [7:0]  SerialCtrl;
  logic [15:0] SerialCom, SerialData;
  logic        SPISel, SPIDo, SPIClk;

  eeprom_serial_ctrl dut (
    .SClk(SClk), .nRst(nRst), .nWE(nWE), .nOE(nOE), .WriteData(WriteData),
    .EEPROMSize(EEPROMSize), .SelSerialCtrl(SelSerialCtrl),
    .SelSerialComLo(SelSerialComLo), .SelSerialComHi(SelSerialComHi),
    .SelSerialDataLo(SelSerialDataLo), .SelSerialDataHi(SelSerialDataHi),
    .SerialCtrl(SerialCtrl), .SerialCom(SerialCom), .SerialData(SerialData),
    .SPISel(SPISel), .SPIDo(SPIDo), .SPIClk(SPIClk)
  );

  always #5 SClk = ~SClk;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] ref_mem [1024];
  bit          ref_valid [1024];
  bit          ref_wren = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          glitches = 0;

  // Byte capture from the SPI pins, sampled between system clock edges.
  logic       sel_prev = 0, clk_prev = 0, do_prev = 0;
  int         bit_cnt = 0;
  logic [7:0] cur_byte = 0;
  always @(negedge SClk) begin
    if (SPISel && !sel_prev) begin
      bit_cnt  = 0;
      cur_byte = 0;
    end
    if (SPISel && SPIClk && !clk_prev) begin
      if (sel_prev && SPIDo !== do_prev) glitches++;
      cur_byte = {cur_byte[6:0], SPIDo};
      bit_cnt++;
      if (bit_cnt == 8) begin
        got_q.push_back(cur_byte);
        bit_cnt = 0;
      end
    end
    sel_prev = SPISel;
    clk_prev = SPIClk;
    do_prev  = SPIDo;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int which, input logic [7:0] d);
    @(negedge SClk);
    WriteData       = d;
    SelSerialCtrl   = (which == 0);
    SelSerialComLo  = (which == 1);
    SelSerialComHi  = (which == 2);
    SelSerialDataLo = (which == 3);
    SelSerialDataHi = (which == 4);
    nWE = 1'b0;
    repeat (2) @(negedge SClk);
    nWE = 1'b1;
    repeat (5) @(negedge SClk);
    {SelSerialCtrl, SelSerialComLo, SelSerialComHi, SelSerialDataLo, SelSerialDataHi} = '0;
  endtask

  task automatic run_cmd(input logic [1:0] size, input logic [15:0] com, input logic [15:0] data);
    int n, op, sub, addr, i;
    bit st, mirror, fill, four;
    EEPROMSize = size;
    wr(1, com[7:0]);
    wr(2, com[15:8]);
    wr(3, data[7:0]);
    wr(4, data[15:8]);
    check("com_readback", SerialCom, com);
    n      = (size == 0) ? 6 : (size == 1) ? 8 : 10;
    st     = com[n + 2];
    op     = (com >> n) & 3;
    sub    = (com >> (n - 2)) & 3;
    addr   = com % (1 << n);
    fill   = (op == 0) && (sub == 1 || sub == 2);
    four   = (op == 1) || (op == 0 && sub == 1);
    mirror = st && ref_wren && (op == 1 || op == 3 || fill);
    exp_q  = {};
    got_q  = {};
    if (mirror) begin
      exp_q.push_back(com[15:8]);
      exp_q.push_back(com[7:0]);
      if (four) begin
        exp_q.push_back(data[15:8]);
        exp_q.push_back(data[7:0]);
      end
    end
    wr(0, (op == 2) ? 8'h10 : (op == 3) ? 8'h40 : 8'h20);
    if (mirror) begin
      check("busy_after_start", SerialCtrl[1], 0);
      if (!fill) begin
        for (i = 0; i < 400 && SPISel; i++) @(negedge SClk);
        check("sel_dropped", SPISel, 0);
        check("ready_low_at_sel_drop", SerialCtrl[1], 0);
        check("spiclk_idle", SPIClk, 0);
        @(negedge SClk);
        check("ready_next_cycle", SerialCtrl[1], 1);
      end else begin
        for (i = 0; i < 3000 && !SerialCtrl[1]; i++) @(negedge SClk);
        check("ready_after_fill", SerialCtrl[1], 1);
      end
    end else begin
      repeat (4) @(negedge SClk);
      check("ready_stays_high", SerialCtrl[1], 1);
    end
    check("spi_byte_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < got_q.size()) check("spi_byte", got_q[k], exp_q[k]);
    check("read_done", SerialCtrl[0], st && op == 2);
    if (st) begin
      if (op == 2 && ref_valid[addr]) check("read_data", SerialData, ref_mem[addr]);
      if (ref_wren && op == 1) begin ref_mem[addr] = data; ref_valid[addr] = 1; end
      if (ref_wren && op == 3) begin ref_mem[addr] = 16'hFFFF; ref_valid[addr] = 1; end
      if (ref_wren && fill)
        for (int k = 0; k < (1 << n); k++) begin
          ref_mem[k] = (sub == 1) ? data : 16'hFFFF;
          ref_valid[k] = 1;
        end
      if (op == 0 && sub == 3) ref_wren = 1;
      if (op == 0 && sub == 0) ref_wren = 0;
    end
  endtask

  initial begin
    int n, kind, op, sub, a;
    bit st;
    logic [1:0] size;
    logic [15:0] com;
    nRst = 1'b0; nWE = 1'b1; nOE = 1'b1; WriteData = 0; EEPROMSize = 0;
    {SelSerialCtrl, SelSerialComLo, SelSerialComHi, SelSerialDataLo, SelSerialDataHi} = '0;
    repeat (3) @(negedge SClk);
    check("rst_ctrl", SerialCtrl, 8'h02);
    check("rst_com", SerialCom, 0);
    check("rst_data", SerialData, 0);
    check("rst_spi", {SPISel, SPIDo, SPIClk}, 0);
    nRst = 1'b1;
    repeat (2) @(negedge SClk);

    run_cmd(0, 16'h0130, 16'h0000);   // EWEN
    run_cmd(0, 16'h0120, 16'h0000);   // ERAL
    run_cmd(0, 16'h0183, 16'h0000);   // READ 3
    run_cmd(0, 16'h0143, 16'hABBA);   // WRITE 3
    run_cmd(0, 16'h0183, 16'h0000);
    run_cmd(0, 16'h017F, 16'h1234);   // WRITE 63
    run_cmd(0, 16'h0140, 16'h7001);   // WRITE 0
    run_cmd(0, 16'h01BF, 16'h0000);
    run_cmd(0, 16'h0180, 16'h0000);
    run_cmd(0, 16'h0110, 16'h3333);   // WRAL
    run_cmd(0, 16'h0180, 16'h0000);
    run_cmd(0, 16'h01BF, 16'h0000);
    run_cmd(0, 16'h0100, 16'h0000);   // EWDS
    run_cmd(0, 16'h01C0, 16'h0000);   // ERASE 0, protected
    run_cmd(0, 16'h0180, 16'h0000);
    run_cmd(0, 16'h0130, 16'h0000);
    run_cmd(0, 16'h01C0, 16'h0000);   // ERASE 0
    run_cmd(0, 16'h0180, 16'h0000);
    run_cmd(2, 16'hF7FF, 16'hC0DE);   // WRITE 1023 with junk high bits
    run_cmd(3, 16'h1BFF, 16'h0000);

    for (int k = 0; k < 30; k++) begin
      size = 2'($urandom_range(0, 3));
      n    = (size == 0) ? 6 : (size == 1) ? 8 : 10;
      kind = $urandom_range(0, 9);
      a    = $urandom_range(0, (1 << n) - 1);
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1) ? 0 : (1 << n) - 1;
      st  = 1;
      sub = 0;
      case (kind)
        0, 1, 2: op = 2;
        3, 4:    op = 1;
        5:       op = 3;
        6:       begin op = 0; sub = 3; end
        7:       begin op = 0; sub = 0; end
        8:       begin op = 0; sub = $urandom_range(1, 2); end
        default: begin op = $urandom_range(0, 3); st = 0; end
      endcase
      if (op == 0 && st) a = (sub << (n - 2)) | (a & ((1 << (n - 2)) - 1));
      com = 16'(($urandom & ~((1 << (n + 3)) - 1)) | (int'(st) << (n + 2)) | (op << n) | a);
      run_cmd(size, com, 16'($urandom));
    end

    run_cmd(0, 16'h0130, 16'h0000);
    EEPROMSize = 0;
    wr(1, 8'h45);
    wr(2, 8'h01);
    wr(3, 8'h5A);
    wr(4, 8'h5A);
    wr(0, 8'h20);
    ref_mem[5] = 16'h5A5A;
    ref_valid[5] = 1;
    check("midwrite_sel_high", SPISel, 1);
    #2 nRst = 1'b0;
    #1;
    check("async_rst_sel", SPISel, 0);
    check("async_rst_clk", SPIClk, 0);
    check("async_rst_ctrl", SerialCtrl, 8'h02);
    check("async_rst_com", SerialCom, 0);
    ref_wren = 0;
    @(negedge SClk);
    nRst = 1'b1;
    @(negedge SClk);
    run_cmd(0, 16'h01C5, 16'h0000);
    run_cmd(0, 16'h0185, 16'h0000);

    check("spido_stable_at_rise", glitches, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
